// File: rtl/alu_sequencer.sv
// Four-cycle multi-cycle sequencer driving an external registered ALU.
// Each instruction runs FETCH, DECODE, EXEC, WB; a halt parks the machine until START.
module alu_sequencer #(
   parameter int             PC_W     = 8,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   output logic [PC_W-1:0] IADDR,
   input  logic [15:0]     IDATA,
   output logic [PC_W-1:0] DADDR,
   input  logic [15:0]     DDATA,
   output logic            DWE,
   output logic [15:0]     DWDATA,
   output logic [3:0]      OP,
   output logic [15:0]     INPUTA,
   output logic [15:0]     INPUTB,
   output logic [15:0]     INPUTC,
   output logic [15:0]     MEMIN,
   input  logic [15:0]     OUT,
   input  logic            ZERO,
   input  logic            EQUAL,
   output logic            BUSY,
   output logic            HALTED,
   output logic            ILLEGAL,
   output logic [PC_W-1:0] PC
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

   localparam logic [3:0] OPC_HALT = 4'd1;
   localparam logic [3:0] OPC_BEQ  = 4'd5;
   localparam logic [3:0] OPC_WM   = 4'd6;
   localparam logic [3:0] OPC_BSQ  = 4'd10;

   state_t          state, nxt;
   logic [PC_W-1:0] pc, pc_inc, pc_br, pc_next, imm_sext;
   logic [15:0]     ir;
   logic [15:0]     rf [16];
   logic [15:0]     op_a, op_b, op_c, memin;
   logic            halted, illegal;
   logic [15:0]     rd_a, rd_b, rd_c;
   logic [3:0]      opc, rd, ra, rb;
   logic            wr_en, taken, is_illegal;

   assign opc = ir[15:12];
   assign rd  = ir[11:8];
   assign ra  = ir[7:4];
   assign rb  = ir[3:0];

   // Register 0 is hardwired to zero on every read port.
   assign rd_a = (ra == 4'd0) ? 16'h0000 : rf[ra];
   assign rd_b = (rb == 4'd0) ? 16'h0000 : rf[rb];
   assign rd_c = (rd == 4'd0) ? 16'h0000 : rf[rd];

   assign wr_en      = (opc inside {4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd12}) && (rd != 4'd0);
   assign is_illegal = opc inside {4'd11, 4'd13, 4'd14, 4'd15};
   assign taken      = ((opc == OPC_BEQ) && EQUAL) || ((opc == OPC_BSQ) && ZERO);
   assign imm_sext   = {{(PC_W-4){rb[3]}}, rb};
   assign pc_inc     = pc + PC_W'(1);
   assign pc_br      = pc_inc + imm_sext;
   assign pc_next    = taken ? pc_br : pc_inc;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (START) nxt = FETCH;
         FETCH:   nxt = DECODE;
         DECODE:  nxt = EXEC;
         EXEC:    nxt = WB;
         WB:      nxt = (opc == OPC_HALT) ? HALT : FETCH;
         HALT:    if (START) nxt = FETCH;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc      <= START_PC;
         ir      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         op_c    <= '0;
         memin   <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else begin
         case (state)
            IDLE: if (START) pc <= START_PC;
            HALT: if (START) begin
               pc     <= START_PC;
               halted <= 1'b0;
            end
            FETCH: ir <= IDATA;
            DECODE: begin
               op_a  <= rd_a;
               op_b  <= rd_b;
               op_c  <= rd_c;
               memin <= DDATA;
            end
            WB: begin
               if (wr_en)      rf[rd]  <= OUT;
               if (is_illegal) illegal <= 1'b1;
               // Halt leaves PC pointing at the halt instruction itself.
               if (opc == OPC_HALT) halted <= 1'b1;
               else                 pc     <= pc_next;
            end
            default: ;
         endcase
      end
   end

   assign IADDR   = pc;
   assign PC      = pc;
   assign DADDR   = rd_a[PC_W-1:0];
   assign OP      = (state == EXEC) ? opc : 4'd0;
   assign DWE     = (state == WB) && (opc == OPC_WM);
   assign DWDATA  = DWE ? OUT : 16'h0000;
   assign INPUTA  = op_a;
   assign INPUTB  = op_b;
   assign INPUTC  = op_c;
   assign MEMIN   = memin;
   assign BUSY    = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
   assign HALTED  = halted;
   assign ILLEGAL = illegal;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PC_W, default 8: width of PC, IADDR and DADDR.
REQ-002 Parameter START_PC, default 0: PC value loaded on reset and on START.
REQ-003 CLK  in  1  rising-edge clock, sole clock.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  one-cycle pulse; begins execution at START_PC.
REQ-006 IADDR  out  PC_W  instruction ROM address; ROM read is combinational.
REQ-007 IDATA  in  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb/imm4.
REQ-008 DADDR  out  PC_W  data memory address = reg[ra][PC_W-1:0].
REQ-009 DDATA  in  16  data memory read data, combinational.
REQ-010 DWE, DWDATA  out  1, 16  data memory write strobe and write data.
REQ-011 OP  out  4  ALU opcode.
REQ-012 INPUTA, INPUTB, INPUTC, MEMIN  out  16 each  ALU operands reg[ra], reg[rb], reg[rd], and latched DDATA.
REQ-013 OUT, ZERO, EQUAL  in  16, 1, 1  ALU result and flags, registered inside the ALU one edge after OP is applied.
REQ-014 BUSY, HALTED, ILLEGAL  out  1 each  status: executing; halt reached; sticky reserved-opcode flag.
REQ-015 PC  out  PC_W  current program counter.

Function
REQ-016 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; every instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-017 IDLE: START=1 -> PC=START_PC, go to FETCH; otherwise stay.
REQ-018 FETCH: IADDR=PC; IR latched from IDATA on the exiting edge.
REQ-019 DECODE: read 16x16 register file; latch operands and MEMIN from DDATA; reg[0] always reads 0.
REQ-020 EXEC: OP=IR[15:12], operands held stable for the whole cycle; OP=0 in every other state.
REQ-021 WB: sample OUT/ZERO/EQUAL; perform writeback, memory write or branch; update PC; go to FETCH.
REQ-022 Writeback to rd=OUT for opcodes 2,3,4,7,8,9,12; writes to rd=0 are discarded.
REQ-023 Opcode 6 (wm): DWE=1 for the WB cycle only, DWDATA=OUT, DADDR=reg[ra]; no register write.
REQ-024 Opcode 5 (beq): if EQUAL, PC=PC+1+sext(imm4), else PC+1.
REQ-025 Opcode 10 (bsq): if ZERO, PC=PC+1+sext(imm4), else PC+1.
REQ-026 All other opcodes: PC=PC+1; PC arithmetic is modulo 2^PC_W (255+1=0 when PC_W=8).
REQ-027 Opcode 0: no-op; no writes.
REQ-028 Opcode 1 (halt): in WB go to HALT; PC not incremented; HALTED=1.
REQ-029 Opcodes 11,13,14,15: treated as no-op; ILLEGAL set and held until RESET.
REQ-030 BUSY=1 in FETCH, DECODE, EXEC and WB; 0 in IDLE and HALT.
REQ-031 START while BUSY is ignored.
REQ-032 START in HALT clears HALTED, reloads START_PC and enters FETCH; register file is kept.

Reset
REQ-033 RESET=1 at any time, including mid-instruction, forces IDLE immediately; pending writeback and DWE are abandoned.
REQ-034 Reset values: PC=START_PC; IADDR=START_PC; OP, operands, MEMIN, DWE, DWDATA, DADDR, BUSY, HALTED and ILLEGAL all 0; register file all 0.

Verification
REQ-035 Stub ALU returns OUT=INPUTA-INPUTB. Program: wr r1, sub r2=r1-r1, halt -> OP sequence 3,2,1 in EXEC cycles 4 apart; HALTED after cycle 12; PC=2.
REQ-036 beq imm4=-2 with EQUAL=1 at PC=5 -> PC=4; with EQUAL=0 -> PC=6.
REQ-037 wm with reg[ra]=0x0012 and OUT=0x00AB -> single-cycle DWE, DADDR=0x12, DWDATA=0x00AB, no register change.
REQ-038 Opcode 13 at PC=3 -> ILLEGAL=1, PC=4, ILLEGAL still 1 after a later START.
REQ-039 RESET asserted during EXEC of sub to r2 -> r2 stays 0, all outputs at reset values before the next edge; nop at PC=255 -> PC wraps to 0.
REQ-040 START pulsed while BUSY -> no effect; START in HALT -> restart at PC=0 with registers intact.
